// File: rtl/alu_seq_pkg.sv
// alu_seq_pkg: shared state encoding and unit-select codes for alu_op_sequencer.
`default_nettype none

package alu_seq_pkg;

  localparam logic [1:0] IDLE  = 2'd0;
  localparam logic [1:0] ISSUE = 2'd1;
  localparam logic [1:0] WAIT  = 2'd2;
  localparam logic [1:0] RESP  = 2'd3;

  localparam logic [1:0] UNIT_ARITH = 2'b00;
  localparam logic [1:0] UNIT_LOGIC = 2'b01;
  localparam logic [1:0] UNIT_CMP   = 2'b10;
  localparam logic [1:0] UNIT_SHIFT = 2'b11;

  // Bit order matches {Shift, CMP, Logic, Arith} enables.
  function automatic logic [3:0] unit_onehot(input logic [1:0] sel);
    return 4'b0001 << sel;
  endfunction

endpackage

`default_nettype wire

// File: rtl/rr_arbiter_2.sv
// rr_arbiter_2: two-way round-robin grant; pointer remembers the last requester served.
`default_nettype none

module rr_arbiter_2 (
  input  logic clk,
  input  logic rst_n,
  input  logic enable,
  input  logic valid0,
  input  logic valid1,
  output logic grant0,
  output logic grant1
);

  logic last_served;

  // On contention the requester not served last wins; reset value 1 favours req0.
  always_comb begin
    grant0 = enable & valid0 & (~valid1 | last_served);
    grant1 = enable & valid1 & (~valid0 | ~last_served);
  end

  always_ff @(posedge clk) begin
    if (!rst_n)      last_served <= 1'b1;
    else if (grant0) last_served <= 1'b0;
    else if (grant1) last_served <= 1'b1;
  end

endmodule

`default_nettype wire

// File: rtl/alu_op_sequencer.sv
// alu_op_sequencer: arbitrates two command sources onto the ALU unit bank and
// returns each unit result tagged with the requester ID.
`default_nettype none

module alu_op_sequencer
  import alu_seq_pkg::*;
#(
  parameter int width   = 16,
  parameter int TIMEOUT = 4
) (
  input  logic             CLK,
  input  logic             RST,
  input  logic             req0_valid,
  output logic             req0_ready,
  input  logic [3:0]       req0_fun,
  input  logic [width-1:0] req0_a,
  input  logic [width-1:0] req0_b,
  input  logic             req1_valid,
  output logic             req1_ready,
  input  logic [3:0]       req1_fun,
  input  logic [width-1:0] req1_a,
  input  logic [width-1:0] req1_b,
  output logic             rsp_valid,
  input  logic             rsp_ready,
  output logic             rsp_id,
  output logic [width-1:0] rsp_data,
  output logic             rsp_err,
  output logic [width-1:0] A,
  output logic [width-1:0] B,
  output logic [1:0]       ALU_FUN,
  output logic             Arith_Enable,
  output logic             Logic_Enable,
  output logic             CMP_Enable,
  output logic             Shift_Enable,
  input  logic [width-1:0] Arith_OUT,
  input  logic [width-1:0] Logic_OUT,
  input  logic [width-1:0] CMP_OUT,
  input  logic [width-1:0] Shift_OUT,
  input  logic             Arith_Flag,
  input  logic             Logic_Flag,
  input  logic             CMP_Flag,
  input  logic             Shift_Flag
);

  localparam int TW = $clog2(TIMEOUT + 1);

  logic [1:0]       state;
  logic [1:0]       sel;
  logic             id_r;
  logic [3:0]       en;
  logic [TW-1:0]    timer;
  logic             grant0;
  logic             grant1;
  logic             sel_flag;
  logic [width-1:0] sel_out;

  rr_arbiter_2 u_arb (
    .clk    (CLK),
    .rst_n  (RST),
    .enable (state == IDLE),
    .valid0 (req0_valid),
    .valid1 (req1_valid),
    .grant0 (grant0),
    .grant1 (grant1)
  );

  assign req0_ready   = grant0;
  assign req1_ready   = grant1;
  assign Arith_Enable = en[0];
  assign Logic_Enable = en[1];
  assign CMP_Enable   = en[2];
  assign Shift_Enable = en[3];

  // Only the selected unit's flag and result are ever observed.
  always_comb begin
    sel_flag = 1'b0;
    sel_out  = '0;
    case (sel)
      UNIT_ARITH: begin sel_flag = Arith_Flag; sel_out = Arith_OUT; end
      UNIT_LOGIC: begin sel_flag = Logic_Flag; sel_out = Logic_OUT; end
      UNIT_CMP:   begin sel_flag = CMP_Flag;   sel_out = CMP_OUT;   end
      default:    begin sel_flag = Shift_Flag; sel_out = Shift_OUT; end
    endcase
  end

  always_ff @(posedge CLK) begin
    if (!RST) begin
      state     <= IDLE;
      sel       <= UNIT_ARITH;
      id_r      <= 1'b0;
      en        <= 4'b0000;
      timer     <= '0;
      A         <= '0;
      B         <= '0;
      ALU_FUN   <= 2'b00;
      rsp_valid <= 1'b0;
      rsp_id    <= 1'b0;
      rsp_data  <= '0;
      rsp_err   <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (grant0 || grant1) begin
            sel     <= grant1 ? req1_fun[3:2] : req0_fun[3:2];
            ALU_FUN <= grant1 ? req1_fun[1:0] : req0_fun[1:0];
            A       <= grant1 ? req1_a : req0_a;
            B       <= grant1 ? req1_b : req0_b;
            en      <= unit_onehot(grant1 ? req1_fun[3:2] : req0_fun[3:2]);
            id_r    <= grant1;
            state   <= ISSUE;
          end
        end
        ISSUE: begin
          en    <= 4'b0000;
          state <= WAIT;
        end
        WAIT: begin
          if (sel_flag) begin
            rsp_data  <= sel_out;
            rsp_err   <= 1'b0;
            rsp_id    <= id_r;
            rsp_valid <= 1'b1;
            state     <= RESP;
          end else begin
            timer <= timer + 1'b1;
            if (timer == TW'(TIMEOUT - 1)) begin
              rsp_data  <= '0;
              rsp_err   <= 1'b1;
              rsp_id    <= id_r;
              rsp_valid <= 1'b1;
              state     <= RESP;
            end
          end
        end
        default: begin
          if (rsp_ready) begin
            rsp_valid <= 1'b0;
            timer     <= '0;
            state     <= IDLE;
          end
        end
      endcase
    end
  end

endmodule

`default_nettype wire

// File: tb/tb_alu_op_sequencer.sv
// tb_alu_op_sequencer: directed vectors against stub ALU units with one-cycle latency.
`default_nettype none

module tb_alu_op_sequencer;

  logic        CLK = 1'b0;
  logic        RST = 1'b0;
  logic        req0_valid = 0, req1_valid = 0;
  logic        req0_ready, req1_ready;
  logic [3:0]  req0_fun = 0, req1_fun = 0;
  logic [15:0] req0_a = 0, req0_b = 0, req1_a = 0, req1_b = 0;
  logic        rsp_valid, rsp_ready = 0, rsp_id, rsp_err;
  logic [15:0] rsp_data, A, B;
  logic [1:0]  ALU_FUN;
  logic        Arith_Enable, Logic_Enable, CMP_Enable, Shift_Enable;
  logic [15:0] Arith_OUT = 0, Logic_OUT = 0, CMP_OUT = 0, Shift_OUT = 0;
  logic [3:0]  flag_r = 0, stuck = 0, inject = 0;
  logic        Arith_Flag, Logic_Flag, CMP_Flag, Shift_Flag;

  int total = 0;
  int bad   = 0;

  always #5 CLK = ~CLK;

  alu_op_sequencer #(.width(16), .TIMEOUT(4)) dut (
    .CLK(CLK), .RST(RST),
    .req0_valid(req0_valid), .req0_ready(req0_ready), .req0_fun(req0_fun),
    .req0_a(req0_a), .req0_b(req0_b),
    .req1_valid(req1_valid), .req1_ready(req1_ready), .req1_fun(req1_fun),
    .req1_a(req1_a), .req1_b(req1_b),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_id(rsp_id),
    .rsp_data(rsp_data), .rsp_err(rsp_err),
    .A(A), .B(B), .ALU_FUN(ALU_FUN),
    .Arith_Enable(Arith_Enable), .Logic_Enable(Logic_Enable),
    .CMP_Enable(CMP_Enable), .Shift_Enable(Shift_Enable),
    .Arith_OUT(Arith_OUT), .Logic_OUT(Logic_OUT), .CMP_OUT(CMP_OUT), .Shift_OUT(Shift_OUT),
    .Arith_Flag(Arith_Flag), .Logic_Flag(Logic_Flag), .CMP_Flag(CMP_Flag), .Shift_Flag(Shift_Flag)
  );

  // Stub units: result and flag registered one cycle after their enable.
  always @(posedge CLK) begin
    flag_r <= {Shift_Enable, CMP_Enable, Logic_Enable, Arith_Enable};
    if (Arith_Enable)
      case (ALU_FUN)
        2'd0: Arith_OUT <= A + B;
        2'd1: Arith_OUT <= A - B;
        2'd2: Arith_OUT <= A * B;
        default: Arith_OUT <= A ^ B;
      endcase
    if (Logic_Enable)
      case (ALU_FUN)
        2'd0: Logic_OUT <= A & B;
        2'd1: Logic_OUT <= A | B;
        2'd2: Logic_OUT <= ~(A & B);
        default: Logic_OUT <= ~(A | B);
      endcase
    if (CMP_Enable)
      case (ALU_FUN)
        2'd0: CMP_OUT <= 16'd0;
        2'd1: CMP_OUT <= (A == B) ? 16'd1 : 16'd0;
        2'd2: CMP_OUT <= (A > B) ? 16'd1 : 16'd0;
        default: CMP_OUT <= (A < B) ? 16'd1 : 16'd0;
      endcase
    if (Shift_Enable)
      case (ALU_FUN)
        2'd0: Shift_OUT <= A >> 1;
        2'd1: Shift_OUT <= A << 1;
        2'd2: Shift_OUT <= B >> 1;
        default: Shift_OUT <= B << 1;
      endcase
  end

  assign {Shift_Flag, CMP_Flag, Logic_Flag, Arith_Flag} = (flag_r & ~stuck) | inject;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  task automatic drive(input logic id, input logic v, input logic [3:0] f,
                       input logic [15:0] a, input logic [15:0] b);
    if (!id) begin req0_valid = v; req0_fun = f; req0_a = a; req0_b = b; end
    else     begin req1_valid = v; req1_fun = f; req1_a = a; req1_b = b; end
  endtask

  // One full transaction; hold>0 keeps rsp_ready low that many cycles in RESP.
  task automatic op(input string nm, input logic id, input logic [3:0] f,
                    input logic [15:0] a, input logic [15:0] b, input logic [15:0] exp_data,
                    input logic exp_err, input int exp_lat, input int hold);
    int n;
    @(negedge CLK);
    drive(id, 1'b1, f, a, b);
    #1;
    n = 0;
    while (!(id ? req1_ready : req0_ready) && n < 20) begin
      @(negedge CLK); #1; n++;
    end
    chk({nm, " ready"}, id ? req1_ready : req0_ready, 1);
    @(negedge CLK);
    drive(id, 1'b0, ~f, ~a, ~b);
    #1;
    chk({nm, " enables"}, {Shift_Enable, CMP_Enable, Logic_Enable, Arith_Enable},
        4'b0001 << f[3:2]);
    chk({nm, " alu_fun"}, ALU_FUN, f[1:0]);
    chk({nm, " operands"}, {A, B}, {a, b});
    n = 0;
    while (!rsp_valid && n < 20) begin
      @(negedge CLK); #1; n++;
    end
    chk({nm, " latency"}, n, exp_lat);
    chk({nm, " data"}, rsp_data, exp_data);
    chk({nm, " id"}, rsp_id, id);
    chk({nm, " err"}, rsp_err, exp_err);
    if (hold > 0) begin
      drive(0, 1'b1, 4'b0000, 16'h1, 16'h1);
      drive(1, 1'b1, 4'b0000, 16'h1, 16'h1);
      for (int h = 0; h < hold; h++) begin
        @(negedge CLK); #1;
        chk({nm, " hold valid"}, rsp_valid, 1);
        chk({nm, " hold data/id"}, {rsp_id, rsp_err, rsp_data}, {id, exp_err, exp_data});
        chk({nm, " hold no ready"}, {req1_ready, req0_ready}, 2'b00);
      end
    end
    rsp_ready = 1;
    @(negedge CLK);
    rsp_ready = 0;
    #1;
    chk({nm, " rsp drop"}, rsp_valid, 0);
    if (hold > 0) begin
      chk({nm, " idle next"}, req0_ready | req1_ready, 1);
      drive(0, 1'b0, 4'b0000, 16'h0, 16'h0);
      drive(1, 1'b0, 4'b0000, 16'h0, 16'h0);
    end
  endtask

  typedef struct {
    logic        id;
    logic [3:0]  fun;
    logic [15:0] a;
    logic [15:0] b;
    logic [15:0] exp;
  } vec_t;

  vec_t vecs[13];

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    int n, got;
    logic r0, r1;

    vecs[0]  = '{1'b0, 4'b1101, 16'h0081, 16'h0000, 16'h0102};
    vecs[1]  = '{1'b1, 4'b1110, 16'h0000, 16'h8001, 16'h4000};
    vecs[2]  = '{1'b0, 4'b0000, 16'h1234, 16'h1111, 16'h2345};
    vecs[3]  = '{1'b1, 4'b0001, 16'h0005, 16'h0007, 16'hFFFE};
    vecs[4]  = '{1'b0, 4'b0010, 16'h0100, 16'h0100, 16'h0000};
    vecs[5]  = '{1'b1, 4'b0100, 16'hF0F0, 16'hFF00, 16'hF000};
    vecs[6]  = '{1'b0, 4'b0101, 16'hF0F0, 16'h0F0F, 16'hFFFF};
    vecs[7]  = '{1'b1, 4'b0110, 16'hF0F0, 16'hFF00, 16'h0FFF};
    vecs[8]  = '{1'b0, 4'b1001, 16'h0007, 16'h0007, 16'h0001};
    vecs[9]  = '{1'b1, 4'b1010, 16'h8000, 16'h7FFF, 16'h0001};
    vecs[10] = '{1'b0, 4'b1011, 16'h8000, 16'h7FFF, 16'h0000};
    vecs[11] = '{1'b1, 4'b1111, 16'h0000, 16'h8001, 16'h0002};
    vecs[12] = '{1'b0, 4'b1100, 16'h0081, 16'h0000, 16'h0040};

    // Reset state
    repeat (2) @(negedge CLK);
    #1;
    chk("reset enables", {Shift_Enable, CMP_Enable, Logic_Enable, Arith_Enable}, 4'b0000);
    chk("reset rsp", {rsp_valid, rsp_err, rsp_id, rsp_data}, 19'd0);
    chk("reset operands", {A, B, ALU_FUN}, 34'd0);
    RST = 1;

    // Both requesters held valid from reset: alternate grants starting with req0
    @(negedge CLK);
    drive(0, 1'b1, 4'b0000, 16'h0001, 16'h0002);
    drive(1, 1'b1, 4'b0100, 16'h0003, 16'h0006);
    rsp_ready = 1;
    n = 0; got = 0;
    while (got < 4 && n < 60) begin
      #1;
      r0 = req0_ready; r1 = req1_ready;
      if (r0 || r1) begin
        chk("rr single grant", {r1, r0} == 2'b11, 0);
        chk("rr order", r1, got % 2);
        got++;
      end
      @(negedge CLK);
      n++;
    end
    drive(0, 1'b0, 4'b0000, 16'h0, 16'h0);
    drive(1, 1'b0, 4'b0000, 16'h0, 16'h0);
    chk("rr grant count", got, 4);
    repeat (6) @(negedge CLK);
    rsp_ready = 0;

    foreach (vecs[i])
      op($sformatf("vec%0d", i), vecs[i].id, vecs[i].fun, vecs[i].a, vecs[i].b,
         vecs[i].exp, 1'b0, 2, 0);

    // Consumer stalls five cycles in RESP
    op("stall", 1'b1, 4'b0101, 16'h00F0, 16'h000F, 16'h00FF, 1'b0, 2, 5);

    // Selected flag stuck low, a foreign flag high throughout
    stuck = 4'b1000; inject = 4'b0001;
    op("timeout", 1'b0, 4'b1101, 16'h0081, 16'h0000, 16'h0000, 1'b1, 5, 0);
    stuck = 4'b0000; inject = 4'b0000;
    op("post timeout", 1'b1, 4'b0000, 16'h0010, 16'h0020, 16'h0030, 1'b0, 2, 0);

    // Reset while WAIT
    @(negedge CLK);
    drive(0, 1'b1, 4'b0000, 16'h0001, 16'h0002);
    #1;
    chk("rst-mid ready", req0_ready, 1);
    @(negedge CLK);
    drive(0, 1'b0, 4'b0000, 16'h0, 16'h0);
    @(negedge CLK);
    RST = 0;
    @(negedge CLK);
    #1;
    chk("rst-mid enables", {Shift_Enable, CMP_Enable, Logic_Enable, Arith_Enable}, 4'b0000);
    chk("rst-mid rsp", {rsp_valid, rsp_err}, 2'b00);
    RST = 1;
    for (int k = 0; k < 3; k++) begin
      @(negedge CLK); #1;
      chk("rst-mid no rsp", rsp_valid, 0);
    end
    op("after rst", 1'b0, 4'b0001, 16'h0009, 16'h0004, 16'h0005, 1'b0, 2, 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

`default_nettype wire
